// File: rtl/router_fsm.sv
// ============================================================================
// Module      : router_fsm
// Description : Ingress controller for the 1x3 router. Decodes the packet
//               header, steers bytes into one of three FIFOs, back-pressures
//               the source, checks the trailing parity byte and soft-resets
//               any FIFO whose reader has stalled for TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_fsm #(
    parameter int TIMEOUT = 30,
    parameter int TO_W    = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic       busy,
    output logic [2:0] write_enb,
    output logic       lfd_state,
    output logic [2:0] soft_reset,
    output logic       parity_err,
    output logic [2:0] vld_out
);

    localparam logic [2:0] c_IDLE         = 3'd0;
    localparam logic [2:0] c_WAIT_EMPTY   = 3'd1;
    localparam logic [2:0] c_LOAD_FIRST   = 3'd2;
    localparam logic [2:0] c_LOAD_DATA    = 3'd3;
    localparam logic [2:0] c_CHECK_PARITY = 3'd4;
    localparam logic [2:0] c_DROP         = 3'd5;

    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [1:0] r_addr;
    logic [5:0] r_len;
    logic [6:0] r_byte_cnt;
    logic [7:0] r_par_acc;
    logic       r_mism;
    logic       r_parity_err;
    logic [2:0] w_soft_reset;

    logic       w_busy;
    logic [2:0] w_write_enb;
    logic       w_lfd;
    logic       w_accept;

    // One-hot select of the latched destination and of the incoming header's dest;
    // a dest of 3 shifts out to zero, which is harmless because it is never loaded.
    logic [2:0] w_sel;
    logic [2:0] w_hdr_sel;
    logic       w_full;
    logic       w_empty;
    logic       w_hdr_empty;
    logic       w_abort;
    logic       w_last;

    assign w_sel       = 3'b001 << r_addr;
    assign w_hdr_sel   = 3'b001 << data_in[1:0];
    assign w_full      = |(fifo_full & w_sel);
    assign w_empty     = |(fifo_empty & w_sel);
    assign w_hdr_empty = |(fifo_empty & w_hdr_sel);
    assign w_abort     = |(w_soft_reset & w_sel);
    assign w_last      = (r_byte_cnt == {1'b0, r_len});

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode and combinational outputs; a soft-reset abort wins over
    // every other transition of an in-flight packet.
    always_comb begin
        w_next      = r_state;
        w_busy      = 1'b0;
        w_write_enb = 3'b000;
        w_lfd       = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (pkt_valid) begin
                    if (data_in[1:0] == 2'b11) w_next = c_DROP;
                    else if (w_hdr_empty)      w_next = c_LOAD_FIRST;
                    else                       w_next = c_WAIT_EMPTY;
                end
            end
            c_WAIT_EMPTY: begin
                w_busy = 1'b1;
                if (w_abort)      w_next = c_DROP;
                else if (w_empty) w_next = c_LOAD_FIRST;
            end
            c_LOAD_FIRST: begin
                w_busy      = 1'b1;
                w_lfd       = 1'b1;
                w_write_enb = w_sel;
                w_next      = w_abort ? c_DROP : c_LOAD_DATA;
            end
            c_LOAD_DATA: begin
                w_busy      = w_full;
                w_accept    = pkt_valid & ~w_full;
                w_write_enb = w_accept ? w_sel : 3'b000;
                if (w_abort)                 w_next = c_DROP;
                else if (w_accept && w_last) w_next = c_CHECK_PARITY;
            end
            c_CHECK_PARITY: begin
                w_busy = 1'b1;
                w_next = c_IDLE;
            end
            c_DROP: begin
                if (!pkt_valid) w_next = c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Header latch, byte counter, running parity and parity result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr       <= 2'd0;
            r_len        <= 6'd0;
            r_byte_cnt   <= 7'd0;
            r_par_acc    <= 8'd0;
            r_mism       <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (pkt_valid && (data_in[1:0] != 2'b11)) begin
                        r_addr <= data_in[1:0];
                        r_len  <= data_in[7:2];
                    end
                end
                c_LOAD_FIRST: begin
                    if (!w_abort) begin
                        r_par_acc    <= {r_len, r_addr};
                        r_byte_cnt   <= 7'd0;
                        r_parity_err <= 1'b0;
                    end
                end
                c_LOAD_DATA: begin
                    if (!w_abort && w_accept) begin
                        if (!w_last) begin
                            r_par_acc  <= r_par_acc ^ data_in;
                            r_byte_cnt <= r_byte_cnt + 7'd1;
                        end else begin
                            r_mism <= (r_par_acc != data_in);
                        end
                    end
                end
                c_CHECK_PARITY: r_parity_err <= r_mism;
                default: ;
            endcase
        end
    end

    // Per-FIFO reader-stall watchdog producing a one-cycle soft_reset pulse.
    for (genvar gi = 0; gi < 3; gi++) begin : g_timeout
        logic [TO_W-1:0] r_to_cnt;
        logic            r_pulse;
        logic            w_stall;

        assign w_stall = ~fifo_empty[gi] & ~read_enb[gi];

        // Count consecutive stalled cycles; fire and restart on the last one.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_to_cnt <= '0;
                r_pulse  <= 1'b0;
            end else if (w_stall) begin
                if (r_to_cnt == c_TO_LAST) begin
                    r_to_cnt <= '0;
                    r_pulse  <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    r_pulse  <= 1'b0;
                end
            end else begin
                r_to_cnt <= '0;
                r_pulse  <= 1'b0;
            end
        end

        assign w_soft_reset[gi] = r_pulse;
    end

    assign busy       = w_busy;
    assign write_enb  = w_write_enb;
    assign lfd_state  = w_lfd;
    assign soft_reset = w_soft_reset;
    assign parity_err = r_parity_err;
    assign vld_out    = ~fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_router_fsm.sv
// ============================================================================
// Module      : tb_router_fsm
// Description : Directed self-checking bench for router_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_router_fsm;

    logic       clock;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic       busy;
    logic [2:0] write_enb;
    logic       lfd_state;
    logic [2:0] soft_reset;
    logic       parity_err;
    logic [2:0] vld_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] body [0:7];
    int         body_n;

    router_fsm #(.TIMEOUT(30), .TO_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .read_enb   (read_enb),
        .busy       (busy),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .soft_reset (soft_reset),
        .parity_err (parity_err),
        .vld_out    (vld_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic pv, input logic [7:0] d);
        pkt_valid = pv;
        data_in   = d;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic b, input logic [2:0] we, input logic lfd);
        check({tag, ".busy"}, 8'(busy), 8'(b));
        check({tag, ".we"},   8'(write_enb), 8'(we));
        check({tag, ".lfd"},  8'(lfd_state), 8'(lfd));
    endtask

    // Sends header + body[] from IDLE into an empty, non-full FIFO.
    task automatic send_pkt(input string tag, input logic [7:0] hdr, input logic [2:0] we_exp,
                            input logic perr_exp);
        drive(1'b1, hdr);
        expect_out({tag, ".idle"}, 1'b0, 3'b000, 1'b0);
        tick();
        expect_out({tag, ".lfirst"}, 1'b1, we_exp, 1'b1);
        tick();
        for (int i = 0; i < body_n; i++) begin
            drive(1'b1, body[i]);
            expect_out({tag, ".data"}, 1'b0, we_exp, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00);
        expect_out({tag, ".chk"}, 1'b1, 3'b000, 1'b0);
        check({tag, ".perr_pre"}, 8'(parity_err), 8'h00);
        tick();
        check({tag, ".perr"}, 8'(parity_err), 8'(perr_exp));
        check({tag, ".idle_after"}, 8'(busy), 8'h00);
    endtask

    initial begin
        reset      = 1'b1;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        read_enb   = 3'b000;
        #2;
        expect_out("rst", 1'b0, 3'b000, 1'b0);
        check("rst.soft", 8'(soft_reset), 8'h00);
        check("rst.perr", 8'(parity_err), 8'h00);
        check("rst.vld",  8'(vld_out), 8'h00);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Good packet, dest 1, L=3.
        body[0] = 8'h11; body[1] = 8'h22; body[2] = 8'h33; body[3] = 8'h0D; body_n = 4;
        send_pkt("t1", 8'h0D, 3'b010, 1'b0);

        // dest 2, L=4, FIFO full for 4 cycles while the third payload byte is held.
        drive(1'b1, 8'h12);
        tick();
        expect_out("t3.lfirst", 1'b1, 3'b100, 1'b1);
        tick();
        drive(1'b1, 8'h01); tick();
        drive(1'b1, 8'h02); tick();
        fifo_full = 3'b100;
        drive(1'b1, 8'h03);
        for (int i = 0; i < 4; i++) begin
            expect_out("t3.full", 1'b1, 3'b000, 1'b0);
            tick();
        end
        fifo_full = 3'b000;
        #1;
        expect_out("t3.release", 1'b0, 3'b100, 1'b0);
        tick();
        drive(1'b1, 8'h04); tick();
        drive(1'b1, 8'h16);
        expect_out("t3.parity", 1'b0, 3'b100, 1'b0);
        tick();
        drive(1'b0, 8'h00);
        tick();
        check("t3.perr", 8'(parity_err), 8'h00);

        // Invalid dest 3: drop header and trailing bytes.
        drive(1'b1, 8'h07);
        expect_out("t4.hdr", 1'b0, 3'b000, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hA0 + 8'(i));
            expect_out("t4.drop", 1'b0, 3'b000, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00);
        expect_out("t4.drop_end", 1'b0, 3'b000, 1'b0);
        tick();
        // IDLE re-entered: a fresh header (dest 1, L=1) loads immediately.
        body[0] = 8'hAA; body[1] = 8'hAF; body_n = 2;
        send_pkt("t4b", 8'h05, 3'b010, 1'b0);

        // Reader timeout on FIFO 0: pulse at cycle 30 only.
        fifo_empty = 3'b110;
        #1;
        check("t5.vld", 8'(vld_out), 8'h01);
        for (int k = 1; k <= 31; k++) begin
            tick();
            check($sformatf("t5.soft%0d", k), 8'(soft_reset), (k == 30) ? 8'h01 : 8'h00);
        end
        fifo_empty = 3'b111;
        tick();
        fifo_empty = 3'b110;
        for (int k = 1; k <= 40; k++) begin
            read_enb = (k == 29) ? 3'b001 : 3'b000;
            tick();
            check($sformatf("t5b.soft%0d", k), 8'(soft_reset), 8'h00);
        end
        read_enb   = 3'b000;
        fifo_empty = 3'b111;
        tick();

        // Bad parity, then parity_err must survive a soft-reset abort.
        body[0] = 8'h11; body[1] = 8'h22; body[2] = 8'h33; body[3] = 8'hFF; body_n = 4;
        send_pkt("t2", 8'h0D, 3'b010, 1'b1);

        fifo_empty = 3'b110;
        drive(1'b1, 8'h04);
        for (int k = 1; k <= 30; k++) begin
            tick();
            expect_out("t7.wait", 1'b1, 3'b000, 1'b0);
        end
        check("t7.soft", 8'(soft_reset), 8'h01);
        tick();
        expect_out("t7.drop", 1'b0, 3'b000, 1'b0);
        check("t7.perr", 8'(parity_err), 8'h01);
        drive(1'b0, 8'h00);
        fifo_empty = 3'b111;
        tick();
        tick();

        // Wait for empty on dest 0, then reset mid-packet.
        fifo_empty = 3'b110;
        drive(1'b1, 8'h04);
        expect_out("t6.idle", 1'b0, 3'b000, 1'b0);
        tick();
        expect_out("t6.wait1", 1'b1, 3'b000, 1'b0);
        tick();
        expect_out("t6.wait2", 1'b1, 3'b000, 1'b0);
        fifo_empty = 3'b111;
        #1;
        expect_out("t6.wait3", 1'b1, 3'b000, 1'b0);
        tick();
        expect_out("t6.lfirst", 1'b1, 3'b001, 1'b1);
        tick();
        drive(1'b1, 8'h55);
        expect_out("t6.data", 1'b0, 3'b001, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        expect_out("t6.rst", 1'b0, 3'b000, 1'b0);
        check("t6.rst.soft", 8'(soft_reset), 8'h00);
        check("t6.rst.perr", 8'(parity_err), 8'h00);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 8'h00);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
